// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   - default address/data widths
//   - grant-source encoding seen on grant_src
//   - default starvation limit and starvation counter width
package rf_arb_pkg;

    localparam int AW_DEF         = 5;
    localparam int DW_DEF         = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int CTR_W          = 4;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_ALU  = 2'b01,
        SRC_MEM  = 2'b10
    } grant_src_e;

endpackage

// File: rtl/rf_arb_starve_ctr.sv
// Starvation guard for the ALU writeback requester.
// Counts consecutive cycles in which the ALU was valid but refused, saturating
// at STARVE_MAX. force_alu is high when the count has reached STARVE_MAX.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   hold         - pipeline stall; the count is frozen while high
//   alu_valid    - ALU request present
//   alu_ready    - ALU request accepted this cycle
//   force_alu    - ALU must win the next contested arbitration
import rf_arb_pkg::*;

module rf_arb_starve_ctr #(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic alu_valid,
    input  logic alu_ready,
    output logic force_alu
);

    localparam logic [CTR_W-1:0] SAT = CTR_W'(STARVE_MAX);

    logic [CTR_W-1:0] count_r;
    logic [CTR_W-1:0] count_nxt_s;

    // Next count: frozen under hold, cleared when the ALU is idle or served.
    always_comb begin
        count_nxt_s = count_r;
        if (hold) begin
            count_nxt_s = count_r;
        end else if (!alu_valid || alu_ready) begin
            count_nxt_s = {CTR_W{1'b0}};
        end else if (count_r < SAT) begin
            count_nxt_s = count_r + {{(CTR_W-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CTR_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign force_alu = (count_r == SAT);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file.
// Two writeback requesters (ALU result, memory load) share one write port.
// MEM has priority; the optional starvation guard forces an ALU grant after
// STARVE_MAX consecutive refusals. The winner is registered onto rf_*.
// Writes to register 0 complete their handshake but leave rf_we low.
// Build option: define RF_WB_STARVE_GUARD_EN to include the starvation guard;
// without it arbitration is pure fixed priority and STARVE_MAX is unused.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   hold                             - stall, no request accepted while high
//   alu_valid/alu_addr/alu_data      - ALU request, alu_ready = accepted
//   mem_valid/mem_addr/mem_data      - load request, mem_ready = accepted
//   rf_we/rf_waddr/rf_wdata          - register file write controls
//   grant_src                        - source of current rf_* write
import rf_arb_pkg::*;

module rf_wb_arbiter #(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [1:0]    grant_src
);

    logic force_alu_s;

`ifdef RF_WB_STARVE_GUARD_EN
    rf_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .force_alu (force_alu_s)
    );
`else
    // Fixed priority: never force the ALU. STARVE_MAX stays in the parameter
    // list so both builds share one interface.
    assign force_alu_s = 1'b0 && (STARVE_MAX > 0);
`endif

    // Grant decode: MEM wins contention unless the guard forces the ALU.
    // Readies are suppressed while in reset or stalled.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!rst_n || hold) begin
            alu_ready = 1'b0;
            mem_ready = 1'b0;
        end else if (alu_valid && mem_valid) begin
            if (force_alu_s) begin
                alu_ready = 1'b1;
            end else begin
                mem_ready = 1'b1;
            end
        end else if (alu_valid) begin
            alu_ready = 1'b1;
        end else if (mem_valid) begin
            mem_ready = 1'b1;
        end else begin
            alu_ready = 1'b0;
            mem_ready = 1'b0;
        end
    end

    // Output register: capture the accepted request; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we     <= 1'b0;
            rf_waddr  <= {AW{1'b0}};
            rf_wdata  <= {DW{1'b0}};
            grant_src <= SRC_NONE;
        end else if (alu_valid && alu_ready) begin
            rf_we     <= (alu_addr != {AW{1'b0}});
            rf_waddr  <= alu_addr;
            rf_wdata  <= alu_data;
            grant_src <= SRC_ALU;
        end else if (mem_valid && mem_ready) begin
            rf_we     <= (mem_addr != {AW{1'b0}});
            rf_waddr  <= mem_addr;
            rf_wdata  <= mem_data;
            grant_src <= SRC_MEM;
        end else begin
            rf_we     <= 1'b0;
            grant_src <= SRC_NONE;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed steps followed by a random
// phase, compared against a cycle-level reference model of the arbitration rules.
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SM = 4;
`ifdef RF_WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hold = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_addr = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          mem_valid = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [1:0]    grant_src;

    int tests = 0;
    int fails = 0;

    // reference model state
    int            m_wait = 0;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    logic [1:0]    e_src = 2'b00;
    logic          e_ardy = 1'b0;
    logic          e_mrdy = 1'b0;

    rf_wb_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_src (grant_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0;
        e_we = 1'b0; e_addr = '0; e_data = '0; e_src = 2'b00;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rf_we"},     {31'd0, rf_we},     {31'd0, e_we});
        check({tag, ".rf_waddr"},  {27'd0, rf_waddr},  {27'd0, e_addr});
        check({tag, ".rf_wdata"},  rf_wdata,           e_data);
        check({tag, ".grant_src"}, {30'd0, grant_src}, {30'd0, e_src});
    endtask

    // One clock of stimulus, starting and ending at a falling edge.
    task automatic do_cycle(input string tag, input logic h,
                            input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                            input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        hold = h;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        e_ardy = 1'b0; e_mrdy = 1'b0;
        if (!h) begin
            if (av && mv) begin
                if (GUARD && m_wait == SM) e_ardy = 1'b1;
                else e_mrdy = 1'b1;
            end else if (av) begin
                e_ardy = 1'b1;
            end else if (mv) begin
                e_mrdy = 1'b1;
            end
        end
        #1;
        check({tag, ".alu_ready"}, {31'd0, alu_ready}, {31'd0, e_ardy});
        check({tag, ".mem_ready"}, {31'd0, mem_ready}, {31'd0, e_mrdy});
        @(posedge clk);
        if (e_ardy) begin
            e_we = (aa != 0); e_addr = aa; e_data = ad; e_src = 2'b01;
        end else if (e_mrdy) begin
            e_we = (ma != 0); e_addr = ma; e_data = md; e_src = 2'b10;
        end else begin
            e_we = 1'b0; e_src = 2'b00;
        end
        if (!h) begin
            if (!av || e_ardy) m_wait = 0;
            else if (m_wait < SM) m_wait++;
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    logic          r_av, r_mv, r_h;
    logic [AW-1:0] r_aa, r_ma;
    logic [DW-1:0] r_ad, r_md;

    initial begin
        // reset with both requesters valid
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hAAAA_0001;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'hBBBB_0002;
        repeat (2) @(posedge clk);
        #1;
        check("rst.alu_ready", {31'd0, alu_ready}, 32'd0);
        check("rst.mem_ready", {31'd0, mem_ready}, 32'd0);
        model_reset();
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // first grant on the first edge after release
        do_cycle("first", 1'b0, 1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd4, 32'hBBBB_0002);
        do_cycle("idle0", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // ALU only
        do_cycle("alu_only", 1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        do_cycle("idle1", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // contention: MEM x4, ALU on the 5th (guard on), then MEM
        for (int i = 0; i < 6; i++)
            do_cycle($sformatf("contend%0d", i), 1'b0, 1'b1, 5'd9, 32'hC0DE_0009,
                     1'b1, 5'd10, 32'h0000_1000 + i);
        do_cycle("idle2", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // write to $0
        do_cycle("zero_wr", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        do_cycle("idle3", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // build count to 2, hold 3 cycles, then resume from the held count
        for (int i = 0; i < 2; i++)
            do_cycle($sformatf("pre_hold%0d", i), 1'b0, 1'b1, 5'd11, 32'h1111_0011,
                     1'b1, 5'd12, 32'h2222_0000 + i);
        for (int i = 0; i < 3; i++)
            do_cycle($sformatf("hold%0d", i), 1'b1, 1'b1, 5'd11, 32'h1111_0011,
                     1'b1, 5'd12, 32'h2222_0010 + i);
        for (int i = 0; i < 3; i++)
            do_cycle($sformatf("post_hold%0d", i), 1'b0, 1'b1, 5'd11, 32'h1111_0011,
                     1'b1, 5'd12, 32'h2222_0020 + i);
        do_cycle("idle4", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // async reset mid-cycle after a grant, with a nonzero starvation count
        for (int i = 0; i < 3; i++)
            do_cycle($sformatf("pre_rst%0d", i), 1'b0, 1'b1, 5'd13, 32'h3333_0013,
                     1'b1, 5'd14, 32'h4444_0000 + i);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            do_cycle($sformatf("after_rst%0d", i), 1'b0, 1'b1, 5'd13, 32'h3333_0013,
                     1'b1, 5'd14, 32'h5555_0000 + i);

        // random phase; refused requests keep their payload stable
        r_av = 1'b0; r_mv = 1'b0;
        r_aa = '0; r_ma = '0; r_ad = '0; r_md = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(r_av && !e_ardy)) begin
                r_av = ($urandom_range(0, 3) != 0);
                r_aa = AW'($urandom_range(0, 31));
                r_ad = $urandom;
            end
            if (!(r_mv && !e_mrdy)) begin
                r_mv = ($urandom_range(0, 3) != 0);
                r_ma = AW'($urandom_range(0, 31));
                r_md = $urandom;
            end
            r_h = ($urandom_range(0, 7) == 0);
            do_cycle("rand", r_h, r_av, r_aa, r_ad, r_mv, r_ma, r_md);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter for the 32x32 register file. Shares the file's single write port between two writeback requesters: the ALU result path and the memory load path. Registers the winning request onto the file's write controls (`RegWrite`, `w_addr`, `w_data`). Drops writes to `$0`, and carries a starvation guard so a stream of loads cannot lock out ALU writeback.

## Interface
Parameters:
- `AW`, 5, register address width.
- `DW`, 32, write data width.
- `STARVE_MAX`, 4, consecutive refused ALU cycles before the ALU is forced to win; legal range 1..15.

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `rst_n`, in, 1, reset, asynchronous, active-low.
- `hold`, in, 1, pipeline stall; while high no request is accepted.
- `alu_valid`, in, 1, ALU writeback request.
- `alu_addr`, in, AW, ALU destination register.
- `alu_data`, in, DW, ALU result.
- `alu_ready`, out, 1, ALU request accepted this cycle.
- `mem_valid`, in, 1, load writeback request.
- `mem_addr`, in, AW, load destination register.
- `mem_data`, in, DW, load data.
- `mem_ready`, out, 1, load request accepted this cycle.
- `rf_we`, out, 1, drives register file `RegWrite`.
- `rf_waddr`, out, AW, drives register file `w_addr`.
- `rf_wdata`, out, DW, drives register file `w_data`.
- `grant_src`, out, 2, source of the current `rf_*` write: 00 none, 01 ALU, 10 MEM.

## Operation
- Transfer occurs on a requester when `valid & ready` are both high at a rising edge.
- While `valid` is high and `ready` is low, the requester holds its address and data stable.
- `ready` is combinational from `valid`, `hold` and the starvation state; there is no path from `ready` back to `valid`.
- Arbitration, evaluated each cycle with `hold` low:
  - Only one requester valid: that requester wins.
  - Both valid: MEM wins, unless the starvation count equals `STARVE_MAX`, in which case the ALU wins.
- At most one of `alu_ready` and `mem_ready` is high in any cycle. Both are low while `hold` is high.
- Output register: on a transfer, capture the winner's address and data into `rf_waddr`/`rf_wdata` and set `grant_src`. `rf_we` = 1 unless the address is 0.
  - A write to `$0` still completes its handshake, with `rf_we` = 0 and `grant_src` still set.
  - With no transfer: `rf_we` = 0 and `grant_src` = 00; `rf_waddr`/`rf_wdata` hold their last value.
- Starvation counter (4 bits):
  - Increments when `alu_valid` is high, `alu_ready` is low and `hold` is low; saturates at `STARVE_MAX`.
  - Clears on an ALU transfer or when `alu_valid` is low.
  - Holds its value while `hold` is high.
- Reset: `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `grant_src` = 00, counter = 0, `alu_ready`/`mem_ready` = 0.
- Reset asserted mid-transfer discards the in-flight write; `rf_we` drops immediately and asynchronously.

## Timing
- Latency: a request accepted at rising edge N appears on `rf_*` from edge N through edge N+1. The register file captures it on the falling edge inside that cycle.
- Throughput: one write per cycle, sustained.
- A requester refused at edge N re-arbitrates at edge N+1 with no bubble.
- Worst-case ALU wait with MEM continuously valid: `STARVE_MAX` cycles, accepted on cycle `STARVE_MAX`+1.
- Back-to-back writes to the same register are issued in order; the later write overwrites the earlier.

## Configuration
- `RF_WB_STARVE_GUARD_EN` defined: the starvation counter and forced ALU grant are built as described above.
- Not defined:
  - Pure fixed priority (MEM over ALU); the counter is absent.
  - The ALU can wait indefinitely while MEM stays valid.
  - `STARVE_MAX` is ignored. Interface is unchanged.

## Structure
- Shared package `rf_arb_pkg`:
  - `AW`/`DW` default constants.
  - Grant-source encoding constants `SRC_NONE`, `SRC_ALU`, `SRC_MEM`.
  - `STARVE_MAX` default.
- Sub-module `rf_arb_starve_ctr`:
  - Contains the saturating counter and the force-ALU flag.
  - Instantiated only under `RF_WB_STARVE_GUARD_EN`.

## Test plan
- Reset: assert `rst_n`=0 with both requesters valid -> all outputs 0, both readies 0; release -> first grant on the next edge.
- ALU only: `alu_valid`=1, addr=5, data=0x1234_5678 -> `alu_ready`=1. Next cycle `rf_we`=1, `rf_waddr`=5, `grant_src`=01.
- Both valid every cycle, `STARVE_MAX`=4, guard on -> MEM granted 4 cycles, ALU on the 5th, then MEM again. Guard off -> MEM every cycle, `alu_ready` never 1.
- `$0` write: `mem_valid`=1, addr=0, data=0xFFFF_FFFF -> `mem_ready`=1, next cycle `rf_we`=0, `grant_src`=10.
- `hold`=1 for 3 cycles with both valid -> no readies, `rf_we`=0, counter unchanged. Release -> arbitration resumes from the held count.
- Async reset pulsed mid-cycle after a grant -> `rf_we` falls without waiting for a clock edge; the counter reads 0 after release.
